// File: rtl/pooling_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pooling_sequencer
// Brief    : Walks a 2x2, stride-2 window across an NxN image. Each window is
//            handed to an external pooling unit with a return-to-zero
//            start/finish handshake. The unit's result is published as one
//            row-major result strobe per window.
// Revision : 1.0 - initial release
// ============================================================================
module pooling_sequencer #(
    parameter int N       = 28,
    parameter int W       = 16,
    parameter int TIMEOUT = 1024,
    localparam int M      = N / 2,
    localparam int RW     = $clog2(N),
    localparam int AW     = (M * M > 1) ? $clog2(M * M) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic                pool_start,
    input  logic                pool_finish,
    input  logic signed [W-1:0] pool_pixel,
    output logic [RW-1:0]       win_row,
    output logic [RW-1:0]       win_col,
    output logic                out_valid,
    output logic [AW-1:0]       out_addr,
    output logic signed [W-1:0] out_data,
    output logic                busy,
    output logic                done,
    output logic                error
);

    // The phase counter only has to reach TIMEOUT-1 before the FSM leaves.
    localparam int                 c_cnt_w    = $clog2(TIMEOUT);
    localparam logic [RW-1:0]      c_last     = RW'(M - 1);
    localparam logic [AW-1:0]      c_m        = AW'(M);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [RW-1:0]      r_ri;
    logic [RW-1:0]      r_ci;
    logic [RW-1:0]      w_ri_nx;
    logic [RW-1:0]      w_ci_nx;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_in_phase;
    logic               w_tmo;
    logic               w_capture;
    logic               w_err_set;
    logic               w_err_clr;

    assign w_in_phase = (r_state == S_ISSUE) || (r_state == S_RELEASE);
    assign w_tmo      = (r_cnt == c_tmo_last);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state and window stepping; abort beats finish, finish beats timeout
    always_comb begin
        w_state_nx = r_state;
        w_ri_nx    = r_ri;
        w_ci_nx    = r_ci;
        w_capture  = 1'b0;
        w_err_set  = 1'b0;
        w_err_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_ISSUE;
                    w_ri_nx    = '0;
                    w_ci_nx    = '0;
                    w_err_clr  = 1'b1;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    w_state_nx = S_IDLE;
                end else if (pool_finish) begin
                    w_capture  = 1'b1;
                    w_state_nx = S_RELEASE;
                end else if (w_tmo) begin
                    w_err_set  = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            S_RELEASE: begin
                if (abort) begin
                    w_state_nx = S_IDLE;
                end else if (!pool_finish) begin
                    if (r_ci != c_last) begin
                        w_ci_nx    = r_ci + RW'(1);
                        w_state_nx = S_ISSUE;
                    end else if (r_ri != c_last) begin
                        w_ci_nx    = '0;
                        w_ri_nx    = r_ri + RW'(1);
                        w_state_nx = S_ISSUE;
                    end else begin
                        w_state_nx = S_DONE;
                    end
                end else if (w_tmo) begin
                    w_err_set  = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Registered outputs, window indices and phase counter, all decoded from next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ri       <= '0;
            r_ci       <= '0;
            r_cnt      <= '0;
            pool_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            win_row    <= '0;
            win_col    <= '0;
        end else begin
            r_ri       <= w_ri_nx;
            r_ci       <= w_ci_nx;
            win_row    <= w_ri_nx << 1;
            win_col    <= w_ci_nx << 1;
            pool_start <= (w_state_nx == S_ISSUE);
            busy       <= (w_state_nx == S_ISSUE) || (w_state_nx == S_RELEASE);
            done       <= (w_state_nx == S_DONE);
            out_valid  <= w_capture;
            if (w_capture) begin
                out_data <= pool_pixel;
                out_addr <= AW'(r_ri) * c_m + AW'(r_ci);
            end
            if (w_err_clr) begin
                error <= 1'b0;
            end else if (w_err_set) begin
                error <= 1'b1;
            end
            // Any state change is a fresh phase, so the count restarts
            if (w_in_phase && (w_state_nx == r_state)) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pooling_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pooling_sequencer
// Brief    : Directed bench for pooling_sequencer. Instance A (N=5) runs
//            against a bench-side pooling unit and a window-index model that
//            is compared on every cycle. Instance B (N=4, TIMEOUT=8) drives
//            a unit that never finishes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pooling_sequencer;

    localparam int N   = 5;
    localparam int TO  = 16;
    localparam int M   = N / 2;
    localparam int RW  = 3;
    localparam int AW  = 2;
    localparam int NB  = 4;
    localparam int TOB = 8;
    localparam int RWB = 2;
    localparam int AWB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic                rst_n;
    logic                start;
    logic                abort;
    logic                pool_start;
    logic                pool_finish;
    logic signed [15:0]  pool_pixel;
    logic [RW-1:0]       win_row;
    logic [RW-1:0]       win_col;
    logic                out_valid;
    logic [AW-1:0]       out_addr;
    logic signed [15:0]  out_data;
    logic                busy;
    logic                done;
    logic                error;

    // Instance B signals
    logic                b_rst_n;
    logic                b_start;
    logic                b_abort;
    logic                b_pool_start;
    logic                b_pool_finish;
    logic signed [15:0]  b_pool_pixel;
    logic [RWB-1:0]      b_win_row;
    logic [RWB-1:0]      b_win_col;
    logic                b_out_valid;
    logic [AWB-1:0]      b_out_addr;
    logic signed [15:0]  b_out_data;
    logic                b_busy;
    logic                b_done;
    logic                b_error;

    pooling_sequencer #(.N(N), .W(16), .TIMEOUT(TO)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .pool_start (pool_start),
        .pool_finish(pool_finish),
        .pool_pixel (pool_pixel),
        .win_row    (win_row),
        .win_col    (win_col),
        .out_valid  (out_valid),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    pooling_sequencer #(.N(NB), .W(16), .TIMEOUT(TOB)) dut_b (
        .clk        (clk),
        .rst_n      (b_rst_n),
        .start      (b_start),
        .abort      (b_abort),
        .pool_start (b_pool_start),
        .pool_finish(b_pool_finish),
        .pool_pixel (b_pool_pixel),
        .win_row    (b_win_row),
        .win_col    (b_win_col),
        .out_valid  (b_out_valid),
        .out_addr   (b_out_addr),
        .out_data   (b_out_data),
        .busy       (b_busy),
        .done       (b_done),
        .error      (b_error)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Image pixel and the 2x2 average the unit produces (truncating division)
    function automatic int img(int r, int c);
        return 10 * r - 3 * c;
    endfunction

    function automatic logic signed [15:0] avg(int r, int c);
        int s;
        s = img(r, c) + img(r, c + 1) + img(r + 1, c) + img(r + 1, c + 1);
        return 16'(s / 4);
    endfunction

    // Pooling unit for instance A: finish follows start one cycle later,
    // optionally stretched by hold_len extra cycles after start drops.
    int hold_len = 0;
    initial begin : unit_a
        logic ps;
        int   hold;
        ps          = 1'b0;
        hold        = 0;
        pool_finish = 1'b0;
        pool_pixel  = '0;
        forever begin
            @(negedge clk);
            ps = (pool_start === 1'b1);
            @(posedge clk);
            #1;
            if (ps) begin
                pool_finish = 1'b1;
                hold        = hold_len;
            end else if (hold > 0) begin
                pool_finish = 1'b1;
                hold--;
            end else begin
                pool_finish = 1'b0;
            end
            pool_pixel = avg(int'(win_row), int'(win_col));
        end
    end

    // Statistics gathered from instance A
    int                 n_valid;
    int                 n_done;
    int                 n_busy;
    int                 n_viol;
    int                 cap_cnt  [4];
    logic signed [15:0] cap_data [4];
    logic [5:0]         cap_win  [4];

    task automatic clear_stats();
        n_valid = 0;
        n_done  = 0;
        n_busy  = 0;
        n_viol  = 0;
        for (int i = 0; i < 4; i++) begin
            cap_cnt[i]  = 0;
            cap_data[i] = '0;
            cap_win[i]  = '0;
        end
    endtask

    // Reference model: window index k walks 0..M*M-1; phase 0 idle, 1 issuing,
    // 2 waiting for finish to drop, 3 done. Stepped once per cycle with the
    // inputs the DUT is about to sample, then compared one cycle later.
    int                 m_ph   = 0;
    int                 m_k    = 0;
    int                 m_cnt  = 0;
    int                 m_addr = 0;
    logic               m_err  = 1'b0;
    logic               m_valid = 1'b0;
    logic signed [15:0] m_data = '0;
    logic               armed  = 1'b0;

    initial begin : compare
        logic [28:0] act_v;
        logic [28:0] exp_v;
        logic        prev_ps;
        prev_ps = 1'b0;
        forever begin
            @(negedge clk);
            if (armed) begin
                act_v = {pool_start, busy, done, error, out_valid,
                         win_row, win_col, out_addr, out_data};
                exp_v = {(m_ph == 1), (m_ph == 1 || m_ph == 2), (m_ph == 3), m_err, m_valid,
                         RW'(2 * (m_k / M)), RW'(2 * (m_k % M)), AW'(m_addr), m_data};
                chk("cycle", 64'(act_v), 64'(exp_v));
                if (out_valid === 1'b1) begin
                    n_valid++;
                    if (!$isunknown(out_addr)) begin
                        cap_cnt[out_addr]++;
                        cap_data[out_addr] = out_data;
                        cap_win[out_addr]  = {win_row, win_col};
                    end
                end
                if (done === 1'b1) n_done++;
                if (busy === 1'b1) n_busy++;
                if (pool_start === 1'b1 && !prev_ps && pool_finish === 1'b1) n_viol++;
                prev_ps = (pool_start === 1'b1);
            end
            m_valid = 1'b0;
            if (rst_n !== 1'b1) begin
                m_ph   = 0;
                m_k    = 0;
                m_cnt  = 0;
                m_addr = 0;
                m_err  = 1'b0;
                m_data = '0;
                armed  = 1'b1;
            end else begin
                case (m_ph)
                    0: if (start) begin
                        m_ph  = 1;
                        m_k   = 0;
                        m_cnt = 0;
                        m_err = 1'b0;
                    end
                    1: if (abort) m_ph = 0;
                       else if (pool_finish) begin
                           m_valid = 1'b1;
                           m_addr  = m_k;
                           m_data  = avg(2 * (m_k / M), 2 * (m_k % M));
                           m_ph    = 2;
                           m_cnt   = 0;
                       end else begin
                           m_cnt++;
                           if (m_cnt == TO) begin m_err = 1'b1; m_ph = 0; end
                       end
                    2: if (abort) m_ph = 0;
                       else if (!pool_finish) begin
                           m_cnt = 0;
                           if (m_k == M * M - 1) m_ph = 3;
                           else begin m_k++; m_ph = 1; end
                       end else begin
                           m_cnt++;
                           if (m_cnt == TO) begin m_err = 1'b1; m_ph = 0; end
                       end
                    default: m_ph = 0;
                endcase
            end
        end
    end

    // Inputs change 2 time units after the rising edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            cyc(1);
            n++;
        end
        chk(name, 64'(done), 64'(1));
    endtask

    logic signed [15:0] exp_data [4] = '{16'sd3, -16'sd2, 16'sd23, 16'sd17};
    logic [5:0]         exp_win  [4] = '{6'o00, 6'o02, 6'o20, 6'o22};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int  cnt;
        logic found;
        rst_n         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        b_rst_n       = 1'b0;
        b_start       = 1'b0;
        b_abort       = 1'b0;
        b_pool_finish = 1'b0;
        b_pool_pixel  = '0;
        clear_stats();
        cyc(3);
        chk("reset_outputs", 64'({pool_start, busy, done, error, out_valid,
                                  win_row, win_col, out_addr, out_data}), 64'(0));
        rst_n   = 1'b1;
        b_rst_n = 1'b1;
        cyc(2);

        // Full N=5 pass: four windows, floor behaviour skips row/col 4
        clear_stats();
        pulse_start();
        wait_done("pass1_done");
        cyc(2);
        chk("pass1_valids", 64'(n_valid), 64'(4));
        chk("pass1_done_pulses", 64'(n_done), 64'(1));
        chk("pass1_busy_cycles", 64'(n_busy), 64'(16));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pass1_addr%0d_count", i), 64'(cap_cnt[i]), 64'(1));
            chk($sformatf("pass1_addr%0d_data", i), 64'(cap_data[i]), 64'(exp_data[i]));
            chk($sformatf("pass1_addr%0d_win", i), 64'(cap_win[i]), 64'(exp_win[i]));
        end

        // Finish held 5 extra cycles: no reissue until it drops
        hold_len = 5;
        clear_stats();
        pulse_start();
        wait_done("hold_done");
        cyc(2);
        hold_len = 0;
        chk("hold_valids", 64'(n_valid), 64'(4));
        chk("hold_done_pulses", 64'(n_done), 64'(1));
        chk("hold_start_while_finish", 64'(n_viol), 64'(0));
        chk("hold_busy_cycles", 64'(n_busy), 64'(36));
        cyc(3);

        // Abort coincident with finish on window 1
        clear_stats();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (pool_start === 1'b1 && pool_finish === 1'b1 &&
                win_row == 3'd0 && win_col == 3'd2) found = 1'b1;
            else cyc(1);
        end
        chk("abort_window_reached", 64'(found), 64'(1));
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("abort_idle", 64'({pool_start, busy, done, out_valid}), 64'(0));
        cyc(3);
        chk("abort_addr1_dropped", 64'(cap_cnt[1]), 64'(0));
        chk("abort_addr0_kept", 64'(cap_cnt[0]), 64'(1));
        chk("abort_no_done", 64'(n_done), 64'(0));
        chk("abort_no_error", 64'(error), 64'(0));

        // Reset during window 2, then restart from the origin
        clear_stats();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (pool_start === 1'b1 && pool_finish === 1'b0 &&
                win_row == 3'd2 && win_col == 3'd0) found = 1'b1;
            else cyc(1);
        end
        chk("reset_window_reached", 64'(found), 64'(1));
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        chk("midpass_reset_outputs", 64'({pool_start, busy, done, error, out_valid,
                                          win_row, win_col, out_addr, out_data}), 64'(0));
        clear_stats();
        cyc(4);
        chk("after_reset_silent", 64'(n_valid + n_done), 64'(0));
        pulse_start();
        chk("restart_origin", 64'({pool_start, win_row, win_col, out_addr}), 64'({1'b1, 8'h00}));
        wait_done("restart_done");
        cyc(2);
        chk("restart_addr0_data", 64'(cap_data[0]), 64'(exp_data[0]));
        chk("restart_valids", 64'(n_valid), 64'(4));

        // Start while busy and during DONE is ignored
        clear_stats();
        pulse_start();
        cyc(3);
        start = 1'b1;
        cyc(2);
        start = 1'b0;
        wait_done("ignore_done");
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(6);
        chk("ignore_done_pulses", 64'(n_done), 64'(1));
        chk("ignore_valids", 64'(n_valid), 64'(4));
        chk("ignore_idle_after", 64'({busy, pool_start}), 64'(0));

        // Instance B: unit never finishes, timeout after 8 ISSUE cycles
        b_start = 1'b1;
        cyc(1);
        b_start = 1'b0;
        cnt = 0;
        while (b_pool_start === 1'b1 && cnt < 40) begin
            cnt++;
            cyc(1);
        end
        chk("tmo_issue_cycles", 64'(cnt), 64'(8));
        chk("tmo_error", 64'(b_error), 64'(1));
        chk("tmo_busy_done", 64'({b_busy, b_done}), 64'(0));
        cyc(3);
        chk("tmo_error_sticky", 64'({b_error, b_done}), 64'(2'b10));
        b_start = 1'b1;
        cyc(1);
        b_start = 1'b0;
        chk("tmo_start_clears", 64'({b_error, b_busy}), 64'(2'b01));

        // Abort on the cycle the timeout would fire: abort wins, error stays low
        cnt = 1;
        while (cnt < 8 && b_pool_start === 1'b1) begin
            cyc(1);
            if (b_pool_start === 1'b1) cnt++;
        end
        chk("prio_reached_cycle8", 64'(cnt), 64'(8));
        b_abort = 1'b1;
        cyc(1);
        b_abort = 1'b0;
        chk("prio_abort_state", 64'({b_error, b_busy, b_pool_start, b_done}), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pooling_sequencer.md
POOLING_SEQUENCER -- requirements
Module: pooling_sequencer

Interface
REQ-001 SHALL have parameter N, default 28: input image side length, N >= 2.
REQ-002 SHALL have parameter W, default 16: pixel width, signed (shortint).
REQ-003 SHALL have parameter TIMEOUT, default 1024: maximum cycles per handshake phase, >= 2.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  begin a full-image pooling pass.
REQ-007 SHALL have port abort  input  1  cancel the pass in progress.
REQ-008 SHALL have port pool_start  output  1  start strobe to the 2x2 pooling unit.
REQ-009 SHALL have port pool_finish  input  1  finish flag from the pooling unit.
REQ-010 SHALL have port pool_pixel  input  W  pooled average from the pooling unit.
REQ-011 SHALL have port win_row, win_col  output  $clog2(N) each  top-left pixel of the current 2x2 window.
REQ-012 SHALL have port out_valid  output  1  one-cycle result strobe.
REQ-013 SHALL have port out_addr  output  $clog2(M*M)  row-major result index, where M = floor(N/2).
REQ-014 SHALL have port out_data  output  W  captured pool_pixel.
REQ-015 SHALL have port busy, done, error  output  1 each  status flags.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, RELEASE and DONE.
REQ-017 SHALL, in IDLE with start=1, on the next edge clear error, zero the row/col indices, enter ISSUE and set busy=1.
REQ-018 SHALL hold pool_start=1 throughout ISSUE and drive pool_start=0 in every other state.
REQ-019 SHALL, in ISSUE with pool_finish=1, register out_data<=pool_pixel, out_addr<=ri*M+ci and out_valid<=1 for exactly one cycle, then enter RELEASE.
REQ-020 SHALL, in RELEASE, wait for pool_finish=0, which enforces the return-to-zero handshake before the next window is issued.
REQ-021 SHALL, on leaving RELEASE when ci<M-1, increment ci and enter ISSUE.
REQ-022 SHALL, on leaving RELEASE when ci=M-1 and ri<M-1, set ci=0, increment ri and enter ISSUE.
REQ-023 SHALL, on leaving RELEASE when ri=ci=M-1, enter DONE.
REQ-024 SHALL drive win_row=2*ri and win_col=2*ci, so the stride is 2 with no overlap.
REQ-025 SHALL, for odd N, never visit the last row or column (floor behaviour).
REQ-026 SHALL, in DONE, assert done=1 for exactly one cycle with busy=0, then return to IDLE.
REQ-027 SHALL ignore start outside IDLE, including start during DONE.
REQ-028 SHALL, on abort=1 in ISSUE or RELEASE, go to IDLE on the next edge with pool_start=0, busy=0 and no done pulse, and discard a simultaneous finish (no out_valid).
REQ-029 SHALL count the cycles spent in the current ISSUE or RELEASE phase and reset the count on every phase entry.
REQ-030 SHALL, when the phase count reaches TIMEOUT, set error=1 and go to IDLE with no done pulse.
REQ-031 SHALL keep error sticky until reset or the next accepted start.
REQ-032 SHALL give abort priority over timeout when both occur in the same cycle, leaving error=0.
REQ-033 SHALL register all outputs, with no combinational path from any input to any output.
REQ-034 SHALL take M*M*(handshake cycles) + 2 cycles for a pass; with a unit that raises finish one cycle after start and drops it one cycle after start is released, each window takes 4 cycles.

Reset
REQ-035 SHALL, when rst_n=0 at a rising edge, force IDLE and drive pool_start=0, busy=0, done=0, error=0, out_valid=0, out_addr=0, out_data=0, win_row=0, win_col=0, and clear the phase counter.
REQ-036 SHALL, on reset mid-pass, drop the pass silently, with no out_valid or done afterwards.

Verification
REQ-037 SHALL check: N=5, start, model unit returns pixel=(sum of 4)/4 -> windows (0,0),(0,2),(2,0),(2,2); out_addr 0,1,2,3 each with exactly one out_valid; a single done pulse; 4 out_valid pulses total.
REQ-038 SHALL check: unit holds finish=1 for 5 cycles after start falls -> no new pool_start until finish=0; still exactly one out_valid per window.
REQ-039 SHALL check: N=4, TIMEOUT=8, unit never finishes -> error=1 after 8 ISSUE cycles; busy=0; done never asserted; next start clears error.
REQ-040 SHALL check: abort asserted in the same cycle as pool_finish on window 1 -> no out_valid for addr 1; IDLE next cycle; pool_start=0.
REQ-041 SHALL check: rst_n=0 during window 2, then start -> all outputs at reset values; new pass restarts at win_row=0, win_col=0, out_addr=0.
REQ-042 SHALL check: start pulsed while busy and again during DONE -> ignored; exactly one pass and one done pulse.
